// File: rtl/gshare_pkg.sv
// gshare_pkg: shared helpers for the gshare branch direction predictor.
//   cnt_ext_t     : counter container wide enough for the largest legal
//                   CNT_WIDTH (4); callers zero-extend into it and
//                   truncate the result back to their own width.
//   counter_init  : weakly-not-taken reset value, 2^(w-1)-1.
//   sat_inc       : saturating increment, clamps at 2^w-1.
//   sat_dec       : saturating decrement, clamps at 0.
//   gshare_index  : pc[..:2] XOR zero-extended history, masked to
//                   pht_width bits.
package gshare_pkg;

    localparam int CNT_WIDTH_MAX = 4;

    typedef logic [CNT_WIDTH_MAX-1:0] cnt_ext_t;

    function automatic cnt_ext_t counter_init(input int cnt_width);
        return cnt_ext_t'((1 << (cnt_width - 1)) - 1);
    endfunction

    function automatic cnt_ext_t sat_inc(input cnt_ext_t cnt, input int cnt_width);
        cnt_ext_t max_val;
        max_val = cnt_ext_t'((1 << cnt_width) - 1);
        return (cnt >= max_val) ? max_val : cnt + cnt_ext_t'(1);
    endfunction

    function automatic cnt_ext_t sat_dec(input cnt_ext_t cnt, input int cnt_width);
        cnt_ext_t ret;
        // Width is carried for symmetry with sat_inc; the floor is always 0.
        ret = (cnt == '0) ? '0 : cnt - cnt_ext_t'(1);
        if (cnt_width < 1) ret = '0;
        return ret;
    endfunction

    // History arrives already zero-extended to 32 bits by the caller.
    function automatic logic [31:0] gshare_index(input logic [31:0] pc,
                                                 input logic [31:0] hist,
                                                 input int          pht_width);
        logic [31:0] mask;
        mask = (32'd1 << pht_width) - 32'd1;
        return ((pc >> 2) ^ hist) & mask;
    endfunction

endpackage

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare branch direction predictor.
// A table of 2^PHT_WIDTH saturating counters is indexed by
// pc[PHT_WIDTH+1:2] XOR a speculative global history register (ghr).
// Queries return the predicted direction and the history used one cycle
// later; resolved branches train the table and, on a misprediction,
// rebuild the ghr from the history carried with the branch.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rdy               : global ready; low freezes all state and outputs
//   query, query_pc   : prediction request from ifetch
//   predict_result    : registered prediction, 1 = taken
//   predict_ghr       : registered history used for that prediction
//   update, update_pc : branch resolution strobe and PC
//   update_ghr        : history snapshot that travelled with the branch
//   update_result     : actual outcome, 1 = taken
//   update_mispredict : with update, restores the ghr
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int PHT_WIDTH  = 6,
    parameter int HIST_WIDTH = 6,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  query,
    input  logic [31:0]           query_pc,
    output logic                  predict_result,
    output logic [HIST_WIDTH-1:0] predict_ghr,
    input  logic                  update,
    input  logic [31:0]           update_pc,
    input  logic [HIST_WIDTH-1:0] update_ghr,
    input  logic                  update_result,
    input  logic                  update_mispredict
);

    localparam int PHT_DEPTH = 1 << PHT_WIDTH;

    logic [CNT_WIDTH-1:0]  pht [PHT_DEPTH];
    logic [HIST_WIDTH-1:0] ghr;

    logic [PHT_WIDTH-1:0]  q_idx_p0;
    logic                  pred_bit_p0;
    logic [HIST_WIDTH-1:0] spec_ghr_p0;
    logic [PHT_WIDTH-1:0]  u_idx_p0;
    cnt_ext_t              u_cnt_ext_p0;
    logic [CNT_WIDTH-1:0]  u_cnt_next_p0;
    logic [HIST_WIDTH-1:0] rec_ghr_p0;
    logic [CNT_WIDTH-1:0]  cnt_reset_val;

    assign cnt_reset_val = CNT_WIDTH'(counter_init(CNT_WIDTH));

    // Stage p0: combinational index, read and counter update
    assign q_idx_p0     = PHT_WIDTH'(gshare_index(query_pc, 32'(ghr), PHT_WIDTH));
    assign pred_bit_p0  = pht[q_idx_p0][CNT_WIDTH-1];
    assign u_idx_p0     = PHT_WIDTH'(gshare_index(update_pc, 32'(update_ghr), PHT_WIDTH));
    assign u_cnt_ext_p0 = cnt_ext_t'(pht[u_idx_p0]);
    assign u_cnt_next_p0 = update_result ? CNT_WIDTH'(sat_inc(u_cnt_ext_p0, CNT_WIDTH))
                                         : CNT_WIDTH'(sat_dec(u_cnt_ext_p0, CNT_WIDTH));

    // A one-bit history has nothing to shift; it is just the newest bit.
    generate
        if (HIST_WIDTH == 1) begin : g_hist_one
            assign spec_ghr_p0 = pred_bit_p0;
            assign rec_ghr_p0  = update_result;
        end else begin : g_hist_wide
            assign spec_ghr_p0 = {ghr[HIST_WIDTH-2:0], pred_bit_p0};
            assign rec_ghr_p0  = {update_ghr[HIST_WIDTH-2:0], update_result};
        end
    endgenerate

    // Stage p1: table, history and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= cnt_reset_val;
            end
            ghr            <= '0;
            predict_result <= 1'b0;
            predict_ghr    <= '0;
        end else if (rdy) begin
            // Query reads the pre-edge counter and history, so a same-cycle
            // update or recovery never bypasses into the prediction.
            if (query) begin
                predict_result <= pred_bit_p0;
                predict_ghr    <= ghr;
            end
            if (update) begin
                pht[u_idx_p0] <= u_cnt_next_p0;
            end
            // Recovery wins over the speculative shift of a concurrent query.
            if (update && update_mispredict) begin
                ghr <= rec_ghr_p0;
            end else if (query) begin
                ghr <= spec_ghr_p0;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor at default parameters.
// A behavioural model (integer counters, integer history) predicts the
// registered outputs after every clock.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        query;
    logic [31:0] query_pc;
    logic        predict_result;
    logic [5:0]  predict_ghr;
    logic        update;
    logic [31:0] update_pc;
    logic [5:0]  update_ghr;
    logic        update_result;
    logic        update_mispredict;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int m_pht [64];
    int m_ghr;
    int m_pr;
    int m_pg;

    gshare_predictor #(.PHT_WIDTH(6), .HIST_WIDTH(6), .CNT_WIDTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .query             (query),
        .query_pc          (query_pc),
        .predict_result    (predict_result),
        .predict_ghr       (predict_ghr),
        .update            (update),
        .update_pc         (update_pc),
        .update_ghr        (update_ghr),
        .update_result     (update_result),
        .update_mispredict (update_mispredict)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_pr  = 0;
        m_pg  = 0;
    endtask

    // One clock of the model, from the behavioural rules: query first reads
    // the old table and history, then the update trains, then history is
    // chosen (recovery beats speculation).
    task automatic model_step();
        int qi, ui, pb, new_ghr;
        if (rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        new_ghr = m_ghr;
        qi = ((query_pc >> 2) ^ m_ghr) % 64;
        pb = (m_pht[qi] >= 2) ? 1 : 0;
        if (query) begin
            m_pr = pb;
            m_pg = m_ghr;
            new_ghr = ((m_ghr * 2) + pb) % 64;
        end
        if (update) begin
            ui = ((update_pc >> 2) ^ int'(update_ghr)) % 64;
            if (update_result) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
            else               m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
            if (update_mispredict) new_ghr = ((int'(update_ghr) * 2) + (update_result ? 1 : 0)) % 64;
        end
        m_ghr = new_ghr;
    endtask

    task automatic idle_inputs();
        rst = 0; rdy = 1; query = 0; query_pc = 0;
        update = 0; update_pc = 0; update_ghr = 0;
        update_result = 0; update_mispredict = 0;
    endtask

    // Advance one clock with the currently driven inputs; outputs are then
    // sampled 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_query(input logic [31:0] pc);
        idle_inputs();
        query = 1; query_pc = pc;
        tick();
        idle_inputs();
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic [5:0] h,
                                input logic res, input logic mis);
        idle_inputs();
        update = 1; update_pc = pc; update_ghr = h;
        update_result = res; update_mispredict = mis;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        idle_inputs();
        checks++;
        if (predict_result !== 1'b0 || predict_ghr !== 6'h00)
            $display("FAIL reset_outputs: got pr=%0b ghr=%h, want pr=0 ghr=00", predict_result, predict_ghr);
        else passes++;
    endtask

    task automatic test_query_basic();
        drive_query(32'h100);
        checks++;
        if (predict_result !== 1'b0 || predict_ghr !== 6'h00)
            $display("FAIL first_query: got pr=%0b ghr=%h, want pr=0 ghr=00", predict_result, predict_ghr);
        else passes++;
    endtask

    task automatic test_train_and_alias();
        drive_update(32'h100, 6'h00, 1'b1, 1'b0);
        drive_update(32'h100, 6'h00, 1'b1, 1'b0);
        drive_query(32'h100);
        checks++;
        if (predict_result !== 1'b1 || predict_ghr !== 6'h00)
            $display("FAIL trained_query: got pr=%0b ghr=%h, want pr=1 ghr=00", predict_result, predict_ghr);
        else passes++;
        // ghr is now 01; pc 0x104 aliases onto entry 0.
        drive_query(32'h104);
        checks++;
        if (predict_result !== 1'b1 || predict_ghr !== 6'h01)
            $display("FAIL alias_query: got pr=%0b ghr=%h, want pr=1 ghr=01", predict_result, predict_ghr);
        else passes++;
    endtask

    task automatic test_recovery();
        // ghr is 03 here; a concurrent query must report 03 while the
        // recovery installs 001011.
        idle_inputs();
        query = 1; query_pc = 32'h0;
        update = 1; update_pc = 32'h200; update_ghr = 6'b000101;
        update_result = 1; update_mispredict = 1;
        tick();
        idle_inputs();
        checks++;
        if (predict_ghr !== 6'h03 || predict_result !== 1'(m_pr))
            $display("FAIL recovery_concurrent: got pr=%0b ghr=%h, want pr=%0d ghr=03", predict_result, predict_ghr, m_pr);
        else passes++;
        drive_query(32'h0);
        checks++;
        if (predict_ghr !== 6'b001011)
            $display("FAIL recovery_ghr: got %b, want 001011", predict_ghr);
        else passes++;
        // Entry 0 ^ 5 = 5 went 01 -> 10; query it with ghr chosen so index = 5.
        drive_query(32'((m_ghr ^ 5) << 2));
        checks++;
        if (predict_result !== 1'b1)
            $display("FAIL recovery_train: got %0b, want 1", predict_result);
        else passes++;
    endtask

    task automatic test_saturation();
        // Entry 0 is at 11; MSB sequence after each update step.
        logic [7:0] want_msb;
        want_msb = 8'b1000_0111;
        for (int i = 0; i < 8; i++) begin
            drive_update(32'h100, 6'h00, (i >= 4), 1'b0);
            drive_query(32'(m_ghr << 2));
            checks++;
            if (predict_result !== want_msb[7-i] || predict_result !== 1'(m_pr))
                $display("FAIL saturation_step%0d: got %0b, want %0b", i, predict_result, want_msb[7-i]);
            else passes++;
        end
    endtask

    task automatic test_rdy_freeze();
        logic       held_pr;
        logic [5:0] held_pg;
        held_pr = 1'(m_pr);
        held_pg = 6'(m_pg);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            rdy = 0; query = 1; query_pc = 32'h0;
            update = 1; update_pc = 32'h0; update_ghr = 6'h2a;
            update_result = 0; update_mispredict = 1;
            tick();
            checks++;
            if (predict_result !== held_pr || predict_ghr !== held_pg)
                $display("FAIL freeze_hold%0d: got pr=%0b ghr=%h, want pr=%0b ghr=%h", i, predict_result, predict_ghr, held_pr, held_pg);
            else passes++;
        end
        idle_inputs();
        drive_query(32'(m_ghr << 2));
        checks++;
        if (predict_ghr !== held_pg[4:0] * 2 + held_pr || predict_result !== 1'b1)
            $display("FAIL freeze_state: got pr=%0b ghr=%h, want pr=1 ghr=%h", predict_result, predict_ghr, 6'(held_pg * 2 + held_pr));
        else passes++;
        // Reset while frozen still applies.
        idle_inputs();
        rst = 1; rdy = 0;
        tick();
        idle_inputs();
        checks++;
        if (predict_result !== 1'b0 || predict_ghr !== 6'h00)
            $display("FAIL reset_frozen: got pr=%0b ghr=%h, want pr=0 ghr=00", predict_result, predict_ghr);
        else passes++;
        drive_query(32'h0);
        checks++;
        if (predict_result !== 1'b0 || predict_ghr !== 6'h00)
            $display("FAIL reset_table: got pr=%0b ghr=%h, want pr=0 ghr=00", predict_result, predict_ghr);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            rdy               = ($urandom_range(0, 7) != 0);
            query             = $urandom_range(0, 1);
            query_pc          = {$urandom_range(0, 15), 2'b00};
            update            = $urandom_range(0, 1);
            update_pc         = {$urandom_range(0, 15), 2'b00};
            update_ghr        = 6'($urandom_range(0, 63));
            update_result     = $urandom_range(0, 1);
            update_mispredict = ($urandom_range(0, 3) == 0);
            rst               = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if (predict_result !== 1'(m_pr) || predict_ghr !== 6'(m_pg))
                $display("FAIL random_cycle%0d: got pr=%0b ghr=%h, want pr=%0d ghr=%h", i, predict_result, predict_ghr, m_pr, 6'(m_pg));
            else passes++;
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        idle_inputs();
        test_reset();
        test_query_basic();
        test_train_and_alias();
        test_recovery();
        test_saturation();
        test_rdy_freeze();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
